// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with shift/rotate/load modes and counted LSB-first serial capture
module shift_reg_univ #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  input  logic [WIDTH-1:0] par_in,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CAPTURE;
        cnt_d   = '0;
      end else begin
        case (mode)
          3'b001:  q_d = {ser_in_r, q_q[WIDTH-1:1]};
          3'b010:  q_d = {q_q[WIDTH-2:0], ser_in_l};
          3'b011:  q_d = {q_q[0], q_q[WIDTH-1:1]};
          3'b100:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          3'b101:  q_d = par_in;
          3'b110:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          default: q_d = q_q;
        endcase
      end
    end else if (state_q == CAPTURE) begin
      q_d     = {ser_in_r, q_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? DONE : CAPTURE;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_2) begin
    if (!reset) begin
      q_q     <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign q         = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];
  assign busy      = state_q == CAPTURE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed self-checking bench for shift_reg_univ at WIDTH 8 and 4
module tb_shift_reg_univ;
  logic       clk_2 = 1'b0;
  logic       reset, ser_in_r, ser_in_l, start;
  logic [2:0] mode;
  logic [7:0] par_in, q;
  logic       ser_out_r, ser_out_l, busy, done;
  logic       reset4, ser_in_r4, start4;
  logic [2:0] mode4;
  logic [3:0] par_in4, q4;
  logic       ser_out_r4, ser_out_l4, busy4, done4;
  int total = 0;
  int bad = 0;
  int busy_cnt;
  logic [7:0] bits;
  logic [3:0] bits4;
  always #5 clk_2 = ~clk_2;
  shift_reg_univ #(.WIDTH(8)) u8 (
    .clk_2(clk_2), .reset(reset), .mode(mode), .ser_in_r(ser_in_r), .ser_in_l(ser_in_l),
    .par_in(par_in), .start(start), .q(q), .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
    .busy(busy), .done(done)
  );
  shift_reg_univ #(.WIDTH(4)) u4 (
    .clk_2(clk_2), .reset(reset4), .mode(mode4), .ser_in_r(ser_in_r4), .ser_in_l(1'b0),
    .par_in(par_in4), .start(start4), .q(q4), .ser_out_r(ser_out_r4), .ser_out_l(ser_out_l4),
    .busy(busy4), .done(done4)
  );
  task automatic step();
    @(posedge clk_2);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_q(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, q}, {24'd0, exp});
    chk({tag, "_sor"}, {31'd0, ser_out_r}, {31'd0, exp[0]});
    chk({tag, "_sol"}, {31'd0, ser_out_l}, {31'd0, exp[7]});
  endtask
  task automatic load(input logic [7:0] v);
    mode = 3'b101;
    par_in = v;
    step();
  endtask
  initial begin
    reset = 1'b0; start = 1'b0; mode = 3'b000; ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = 8'h00;
    reset4 = 1'b0; start4 = 1'b0; mode4 = 3'b000; ser_in_r4 = 1'b0; par_in4 = 4'h0;
    step(); step();
    chk_q("rst_q", 8'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1; reset4 = 1'b1;
    load(8'hA5); chk_q("load_a5", 8'hA5);
    mode = 3'b001; ser_in_r = 1'b1; step(); chk_q("shr", 8'hD2);
    load(8'hA5); mode = 3'b010; ser_in_l = 1'b0; step(); chk_q("shl", 8'h4A);
    load(8'hA5); mode = 3'b011; step(); chk_q("ror", 8'hD2);
    load(8'hA5); mode = 3'b100; step(); chk_q("rol", 8'h4B);
    load(8'hA5); mode = 3'b110; step(); chk_q("asr_neg", 8'hD2);
    load(8'h25); mode = 3'b110; step(); chk_q("asr_pos", 8'h12);
    mode = 3'b111; step(); chk_q("mode7_hold", 8'h12);
    mode = 3'b000; step(); chk_q("hold", 8'h12);
    load(8'h81); mode = 3'b011; step(); chk_q("ror_wrap1", 8'hC0);
    for (int i = 0; i < 7; i++) step();
    chk_q("ror_wrap8", 8'h81);
    load(8'hFF);
    mode = 3'b000; start = 1'b1; step();
    start = 1'b0;
    chk_q("cap_enter_hold", 8'hFF);
    busy_cnt = busy ? 1 : 0;
    bits = 8'b0100_1101;
    for (int i = 0; i < 8; i++) begin
      ser_in_r = bits[i];
      mode = (i % 2 == 0) ? 3'b101 : 3'b000;
      par_in = 8'hA5;
      step();
      if (busy) busy_cnt++;
      if (i < 7) chk("cap_no_early_done", {31'd0, done}, 32'd0);
    end
    chk("cap_busy_cycles", busy_cnt, 32'd8);
    chk("cap_done", {31'd0, done}, 32'd1);
    chk_q("cap_q", 8'h4D);
    mode = 3'b000; step();
    chk("cap_done_pulse", {31'd0, done}, 32'd0);
    chk("cap_idle_busy", {31'd0, busy}, 32'd0);
    chk_q("cap_hold", 8'h4D);
    start = 1'b1; step(); start = 1'b0;
    ser_in_r = 1'b1;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0; step();
    chk_q("abort_q", 8'h00);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b1; step();
    chk("abort_no_done", {31'd0, done}, 32'd0);
    start = 1'b1; step(); start = 1'b0;
    bits = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      ser_in_r = bits[i];
      step();
    end
    chk("recap_done", {31'd0, done}, 32'd1);
    chk_q("recap_q", 8'hC3);
    step();
    reset = 1'b0; start = 1'b1; step();
    reset = 1'b1; step();
    chk("rst_start_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    busy_cnt = 0;
    while (!done && busy_cnt < 20) begin
      step();
      busy_cnt++;
    end
    chk("rst_start_len", busy_cnt, 32'd8);
    mode4 = 3'b101; par_in4 = 4'h9; step();
    chk("w4_load", {28'd0, q4}, 32'h9);
    mode4 = 3'b011; step();
    chk("w4_ror", {28'd0, q4}, 32'hC);
    mode4 = 3'b110; step();
    chk("w4_asr", {28'd0, q4}, 32'hE);
    chk("w4_sol", {31'd0, ser_out_l4}, 32'd1);
    chk("w4_sor", {31'd0, ser_out_r4}, 32'd0);
    mode4 = 3'b000; start4 = 1'b1; step(); start4 = 1'b0;
    busy_cnt = busy4 ? 1 : 0;
    bits4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      ser_in_r4 = bits4[i];
      step();
      if (busy4) busy_cnt++;
    end
    chk("w4_busy_cycles", busy_cnt, 32'd4);
    chk("w4_done", {31'd0, done4}, 32'd1);
    chk("w4_cap_q", {28'd0, q4}, 32'hB);
    step();
    chk("w4_done_clear", {31'd0, done4}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register with an N-bit datapath, seven shift/rotate/load modes, two serial inputs and outputs, and a counted serial-capture mode that raises `done` after exactly WIDTH bits. It is the successor to the fixed 4-bit serial/parallel shift register in the board-level `top`. It is driven from SWI-mapped controls under `clk_2`, with `q` routed to LED/SEG.

## Interface
- `WIDTH`, default 8: register width in bits, minimum 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: capture counter width, derived, not overridden.

Ports:
- `clk_2` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset, sampled on `clk_2` rising edge.
- `mode` in 3: operation select, sampled every cycle while IDLE.
- `ser_in_r` in 1: bit entering the MSB on right shift and on capture.
- `ser_in_l` in 1: bit entering the LSB on left shift.
- `par_in` in WIDTH: parallel load data.
- `start` in 1: begins a serial capture, level-sampled.
- `q` out WIDTH: register contents.
- `ser_out_r` out 1: equals `q[0]`, the bit leaving on right shift.
- `ser_out_l` out 1: equals `q[WIDTH-1]`, the bit leaving on left shift.
- `busy` out 1: high while in CAPTURE.
- `done` out 1: one-cycle pulse at capture completion.

## Operation
Modes, applied every cycle in IDLE when `start` is low:
- 000 HOLD: `q` unchanged.
- 001 SHR: `q <= {ser_in_r, q[WIDTH-1:1]}`.
- 010 SHL: `q <= {q[WIDTH-2:0], ser_in_l}`.
- 011 ROR: `q <= {q[0], q[WIDTH-1:1]}`.
- 100 ROL: `q <= {q[WIDTH-2:0], q[WIDTH-1]}`.
- 101 LOAD: `q <= par_in`.
- 110 ASR: `q <= {q[WIDTH-1], q[WIDTH-1:1]}`, sign bit preserved.
- 111: treated as HOLD.

Capture FSM, states IDLE, CAPTURE and DONE:
- IDLE: if `start` is high, the next state is CAPTURE and `cnt <= 0`. The `mode` input is ignored that cycle and `q` holds.
- CAPTURE: each cycle `q` shifts right with `ser_in_r`, the same as SHR, and `cnt <= cnt+1`.
  - When the shift that makes `cnt` equal WIDTH occurs, the next state is DONE.
  - `mode` and `start` are ignored throughout CAPTURE.
- DONE: `done` is 1 for this one cycle, `q` holds, `busy` is 0, and the next state is IDLE unconditionally.
  - `start` is ignored in DONE. A capture restart needs `start` high in a following IDLE cycle.
- After a capture, the first bit sampled sits in `q[0]` and the last bit sampled sits in `q[WIDTH-1]`, i.e. LSB-first framing.

Reset, when `reset` is low at a rising edge:
- Resulting values: `q=0`, state IDLE, `cnt=0`, `busy=0`, `done=0`.
- Reset has priority over everything, including mid-capture. An aborted capture produces no `done`.

Outputs:
- `ser_out_r` and `ser_out_l` are combinational from `q` and carry no extra register.
- `busy` and `done` are decoded from the state register and are glitch-free.

## Timing
- Mode operations have a latency of 1 cycle: an input sampled at edge k appears on `q` after edge k.
- Capture takes WIDTH+2 cycles from the edge where `start` is sampled to the return to IDLE:
  - 1 cycle to enter CAPTURE.
  - WIDTH shift cycles.
  - 1 DONE cycle.
- `busy` is high for exactly WIDTH cycles per capture.
- `ser_in_r` is sampled on each of the WIDTH CAPTURE-state edges.
- The earliest back-to-back capture has `start` high in the IDLE cycle after DONE, giving a period of WIDTH+2 cycles.
- Reset deasserting with `start` already high: the first edge with `reset` high enters CAPTURE.

## Test plan
1. Reset and load:
   - Hold `reset` low for 2 cycles → `q=0x00`, `busy=0`, `done=0`.
   - Release reset, then `mode=101` with `par_in=0xA5` for 1 cycle → `q=0xA5`.
2. Shifts, all from `q=0xA5`:
   - SHR with `ser_in_r=1` → `0xD2`.
   - Reload, then SHL with `ser_in_l=0` → `0x4A`.
   - Reload, then ROR → `0xD2`.
   - Reload, then ROL → `0x4B`.
   - Reload, then ASR → `0xD2`.
   - Reload, then load `0x25` and apply ASR → `0x12`.
   - Check that `ser_out_r` and `ser_out_l` track `q[0]` and `q[7]` in every case.
3. Rotate wrap-around:
   - Load `0x81`, then apply ROR for 8 cycles → `q` returns to `0x81` after 8 cycles.
   - The intermediate value after 1 cycle is `0xC0`.
4. Capture:
   - From `q=0xFF`, pulse `start`, then drive `ser_in_r` with 1,0,1,1,0,0,1,0 on successive CAPTURE cycles → `busy` is high for 8 cycles.
   - `done` pulses once, the cycle after the last shift.
   - Final `q=0x4D`, held while `mode=000`.
   - `mode=101` toggled during CAPTURE has no effect.
5. Reset mid-capture:
   - Assert `reset` low after the 3rd capture shift → `q=0`, `busy=0` on the next cycle.
   - No `done` pulse occurs. A fresh `start` completes a normal 8-bit capture.
6. Parameter sweep:
   - Repeat scenarios 2–4 with `WIDTH=4` and `WIDTH=16` → capture takes WIDTH+2 cycles.
   - `cnt` saturates at no point beyond WIDTH.
   - Load, shift and rotate results match a reference model bit-exactly.
